regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/execute writeback) and B (load/multiply writeback).
- Round-robin arbitration with a valid/ready handshake on each requester.
- Registered write-port outputs (W_en, W_Addr, W_Data) drive the register file's write port directly.
- Writes to register 0 (MIPS $zero) are suppressed; an optional bypass serves pending writes to the read ports.

Parameters:
- D_WIDTH, 32, data width; must match the register file's data width.
- RA_WIDTH, 5, register address width; 2**RA_WIDTH registers.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-high
- hold  in  1  write-port stall; no grants while high
- a_valid  in  1  requester A has a write
- a_addr  in  RA_WIDTH  A destination register
- a_data  in  D_WIDTH  A write data
- a_ready  out  1  A write accepted this cycle (combinational)
- b_valid  in  1  requester B has a write
- b_addr  in  RA_WIDTH  B destination register
- b_data  in  D_WIDTH  B write data
- b_ready  out  1  B write accepted this cycle (combinational)
- W_en  out  1  register-file write enable (registered)
- W_Addr  out  RA_WIDTH  register-file write address (registered)
- W_Data  out  D_WIDTH  register-file write data (registered)
- collision  out  1  registered pulse: A and B valid, same nonzero address, same cycle

Behaviour:
- State: 1-bit last-grant pointer ptr (0=A, 1=B), output registers, collision register.
- Reset values: W_en=0, W_Addr=0, W_Data=0, collision=0, ptr=1 (A wins the first tie).
- Grant is combinational and suppressed when hold=1:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant A if ptr==1, else grant B.
- Acceptance: a_ready = grantA, b_ready = grantB; never both high in one cycle. A requester holds valid/addr/data stable until ready.
- Pointer: ptr updates to the granted ID on every grant; it is unchanged when there is no grant or hold=1.
- Latency: a write accepted in cycle N appears on W_* in cycle N+1 with W_en=1 for exactly one cycle. W_en=0 when nothing is accepted. W_Addr and W_Data hold their last value while W_en=0.
- Address 0: the request is accepted (ready=1) and ptr updates, but W_en stays 0 the next cycle.
- Same-address tie: the winner writes at N+1 and the loser at N+2 or later. The loser's value is therefore final in the register file. collision=1 at N+1 for one cycle; it is not asserted for address 0.
- Fairness: with both valid continuously, grants alternate A,B,A,B. Wait is at most 1 cycle when hold=0.
- hold=1: a_ready=b_ready=0, W_en=0 the following cycle, ptr frozen.
- Reset mid-operation: the accepted-but-unissued write is discarded and W_en=0 next cycle. Reset dominates hold and valid.

Optional Feature:
- Macro: RF_ARB_BYPASS_EN.
- Defined: adds ports r1_addr, r2_addr (in, RA_WIDTH), r1_rf_data, r2_rf_data (in, D_WIDTH), r1_data, r2_data (out, D_WIDTH).
  - rX_data = W_Data when W_en=1 and W_Addr==rX_addr and rX_addr!=0; otherwise rX_rf_data.
  - Purely combinational; forwards the write issuing this cycle before the register file captures it.
- Undefined: these ports do not exist; readers use the register file's read ports directly.

Decomposition:
- Shared package rf_pkg: D_WIDTH and RA_WIDTH defaults (same values as define.h), REG_COUNT = 2**RA_WIDTH, REQ_A=1'b0, REQ_B=1'b1, ZERO_REG=0.
- Sub-module rf_rr_arb2: 2-way round-robin grant logic plus ptr register (inputs req[1:0], hold; outputs gnt[1:0]).
- The top level holds the output registers, zero-register suppression, collision detect and the optional bypass.

Test Plan:
- Reset, then a_valid=1, a_addr=3, a_data=0x11 → a_ready=1 same cycle; next cycle W_en=1, W_Addr=3, W_Data=0x11; following cycle W_en=0.
- A and B valid continuously for 4 cycles, addrs 4 and 5 → grants A,B,A,B; W_Addr sequence 4,5,4,5; no cycle with both readies high.
- Both valid, a_addr=b_addr=7, a_data=0xA, b_data=0xB, ptr=1 → A granted, collision=1 next cycle; register 7 ends at 0xB.
- a_valid=1, a_addr=0, a_data=0xFF → a_ready=1; W_en stays 0 for every cycle.
- hold=1 for 3 cycles with both valid → both readies 0, W_en 0; on hold release, the grant follows the pre-hold ptr.
- With RF_ARB_BYPASS_EN: W_en=1, W_Addr=9, W_Data=0x55, r1_addr=9, r1_rf_data=0x0 → r1_data=0x55; with r1_addr=0 → r1_data=r1_rf_data.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter slice.
package rf_pkg;

  localparam int unsigned D_WIDTH   = 32;
  localparam int unsigned RA_WIDTH  = 5;
  localparam int unsigned REG_COUNT = 2 ** RA_WIDTH;

  // Requester IDs double as bit positions in the req/gnt vectors.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes and register-file write port of the write arbiter.
// RF_ARB_BYPASS_EN adds the read-port forwarding signals.
interface regfile_write_arbiter_if
  import rf_pkg::*;
#(
  parameter int unsigned D_WIDTH  = rf_pkg::D_WIDTH,
  parameter int unsigned RA_WIDTH = rf_pkg::RA_WIDTH
);

  logic                hold;
  logic                a_valid;
  logic [RA_WIDTH-1:0] a_addr;
  logic [D_WIDTH-1:0]  a_data;
  logic                a_ready;
  logic                b_valid;
  logic [RA_WIDTH-1:0] b_addr;
  logic [D_WIDTH-1:0]  b_data;
  logic                b_ready;
  logic                W_en;
  logic [RA_WIDTH-1:0] W_Addr;
  logic [D_WIDTH-1:0]  W_Data;
  logic                collision;
`ifdef RF_ARB_BYPASS_EN
  logic [RA_WIDTH-1:0] r1_addr;
  logic [RA_WIDTH-1:0] r2_addr;
  logic [D_WIDTH-1:0]  r1_rf_data;
  logic [D_WIDTH-1:0]  r2_rf_data;
  logic [D_WIDTH-1:0]  r1_data;
  logic [D_WIDTH-1:0]  r2_data;
`endif

  modport master (
    output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
`ifdef RF_ARB_BYPASS_EN
    output r1_addr, r2_addr, r1_rf_data, r2_rf_data,
    input  r1_data, r2_data,
`endif
    input  a_ready, b_ready, W_en, W_Addr, W_Data, collision
  );

  modport slave (
    input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
`ifdef RF_ARB_BYPASS_EN
    input  r1_addr, r2_addr, r1_rf_data, r2_rf_data,
    output r1_data, r2_data,
`endif
    output a_ready, b_ready, W_en, W_Addr, W_Data, collision
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer; no grants while hold is high.
module rf_rr_arb2
  import rf_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (!hold) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Tie: the requester that did not win last time goes first.
        2'b11:   gnt = (ptr_q == REQ_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
      if (gnt[REQ_A]) begin
        ptr_d = REQ_A;
      end else if (gnt[REQ_B]) begin
        ptr_d = REQ_B;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q <= REQ_B;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between requesters A and B.
// Define RF_ARB_BYPASS_EN to add combinational read-port forwarding.
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned D_WIDTH  = rf_pkg::D_WIDTH,
  parameter int unsigned RA_WIDTH = rf_pkg::RA_WIDTH
) (
  input logic                    Clk,
  input logic                    Rst,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [RA_WIDTH-1:0] ZeroAddr = RA_WIDTH'(ZERO_REG);

  logic [1:0]          req;
  logic [1:0]          gnt;
  logic [RA_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0]  sel_data;
  logic                wr_en_d;
  logic                collision_d;

  assign req = {bus.b_valid, bus.a_valid};

  rf_rr_arb2 u_arb (
    .Clk  (Clk),
    .Rst  (Rst),
    .req  (req),
    .hold (bus.hold),
    .gnt  (gnt)
  );

  assign bus.a_ready = gnt[REQ_A];
  assign bus.b_ready = gnt[REQ_B];

  always_comb begin
    sel_addr    = gnt[REQ_B] ? bus.b_addr : bus.a_addr;
    sel_data    = gnt[REQ_B] ? bus.b_data : bus.a_data;
    // Writes to $zero are accepted but never reach the register file.
    wr_en_d     = (|gnt) && (sel_addr != ZeroAddr);
    collision_d = bus.a_valid && bus.b_valid && (bus.a_addr == bus.b_addr) &&
                  (bus.a_addr != ZeroAddr);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.W_en      <= 1'b0;
      bus.W_Addr    <= '0;
      bus.W_Data    <= '0;
      bus.collision <= 1'b0;
    end else begin
      bus.W_en      <= wr_en_d;
      bus.collision <= collision_d;
      if (wr_en_d) begin
        bus.W_Addr <= sel_addr;
        bus.W_Data <= sel_data;
      end
    end
  end

`ifdef RF_ARB_BYPASS_EN
  // Forward the write issuing this cycle, before the register file captures it.
  assign bus.r1_data = (bus.W_en && (bus.W_Addr == bus.r1_addr) && (bus.r1_addr != ZeroAddr)) ?
                       bus.W_Data : bus.r1_rf_data;
  assign bus.r2_data = (bus.W_en && (bus.W_Addr == bus.r2_addr) && (bus.r2_addr != ZeroAddr)) ?
                       bus.W_Data : bus.r2_rf_data;
`endif

endmodule
